// File: rtl/fdvit_resample_pkg.sv
// Shared types and constant helpers for the FD-ViT resampling blocks (up and down).
package fdvit_resample_pkg;

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  // Rounded interpolation weight for axis remainder r; 1.0 == 2**frac_w.
  function automatic int unsigned wtab(input int unsigned r, input int unsigned hout,
                                       input int unsigned frac_w);
    return (r * (32'd1 << frac_w) + (hout - 1) / 2) / (hout - 1);
  endfunction

  // Width of one horizontal lerp sum: 8-bit pixel times a (frac_w+1)-bit weight.
  function automatic int hsum_w(input int frac_w);
    return 8 + frac_w + 1;
  endfunction

endpackage

// File: rtl/bilinear_interp_pipe.sv
// Two-stage bilinear lerp: horizontal sums registered, then vertical blend, round and saturate.
// Latency 2 cycles; every register freezes while adv is low, so outputs hold under backpressure.
module bilinear_interp_pipe
  import fdvit_resample_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic            issue_valid,
  input  logic            issue_last,
  input  logic [7:0]      p00,
  input  logic [7:0]      p01,
  input  logic [7:0]      p10,
  input  logic [7:0]      p11,
  input  logic [FRAC_W:0] wx,
  input  logic [FRAC_W:0] wy,
  output logic            out_valid,
  output logic [7:0]      out_data,
  output logic            out_last
);

  localparam int HW = hsum_w(FRAC_W);
  localparam int VW = HW + FRAC_W + 1;
  localparam logic [FRAC_W:0] ONE  = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [VW-1:0]   HALF = VW'(1) << (2 * FRAC_W - 1);

  logic [HW-1:0]   ht, hb, s1_ht, s1_hb;
  logic [FRAC_W:0] s1_wy;
  logic            s1_valid, s1_last;
  logic [VW-1:0]   v, vsh;
  logic [7:0]      sat;

  assign ht  = HW'(p00) * HW'(ONE - wx) + HW'(p01) * HW'(wx);
  assign hb  = HW'(p10) * HW'(ONE - wx) + HW'(p11) * HW'(wx);
  assign v   = VW'(s1_ht) * VW'(ONE - s1_wy) + VW'(s1_hb) * VW'(s1_wy) + HALF;
  assign vsh = v >> (2 * FRAC_W);
  assign sat = (|vsh[VW-1:8]) ? 8'hff : vsh[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (adv) begin
      s1_valid  <= issue_valid;
      s1_last   <= issue_valid & issue_last;
      out_valid <= s1_valid;
      out_last  <= s1_valid & s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_ht    <= ht;
      s1_hb    <= hb;
      s1_wy    <= wy;
      out_data <= sat;
    end
  end

endmodule

// File: rtl/bilinear_upsample_stream.sv
// Buffers one HIN x HIN frame, then streams the HOUT x HOUT align-corners bilinear upsample.
// Output 2 cycles after RUN entry, one pixel/cycle; coordinates and pipe stall on out_ready low.
module bilinear_upsample_stream
  import fdvit_resample_pkg::*;
#(
  parameter int HIN    = 19,
  parameter int HOUT   = 27,
  parameter int FRAC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int NPIX = HIN * HIN;
  localparam int AW   = $clog2(NPIX);
  localparam int IW   = $clog2(HIN);
  localparam int RW   = $clog2(HOUT);
  localparam int WW   = FRAC_W + 1;

  state_t          state;
  logic [AW-1:0]   lcnt;
  logic [7:0]      mem [NPIX];
  logic [RW-1:0]   ox, oy, xr, yr, xr_next, yr_next;
  logic [IW-1:0]   xi, yi, x_hi, y_hi;
  logic [RW:0]     xsum, ysum;
  logic            xwrap, ywrap, row_end, frame_end, adv, issue_valid;
  logic [FRAC_W:0] wt [HOUT-1];
  logic [FRAC_W:0] wx, wy;
  logic [7:0]      p00, p01, p10, p11;

  for (genvar g = 0; g < HOUT - 1; g++) begin : g_wtab
    assign wt[g] = WW'(wtab(g, HOUT, FRAC_W));
  end

  function automatic logic [AW-1:0] pix_addr(input logic [IW-1:0] y, input logic [IW-1:0] x);
    return AW'(y) * AW'(HIN) + AW'(x);
  endfunction

  // Per-axis source position: index plus remainder in units of 1/(HOUT-1).
  assign xsum    = {1'b0, xr} + (RW+1)'(HIN - 1);
  assign ysum    = {1'b0, yr} + (RW+1)'(HIN - 1);
  assign xwrap   = xsum >= (RW+1)'(HOUT - 1);
  assign ywrap   = ysum >= (RW+1)'(HOUT - 1);
  assign xr_next = xwrap ? RW'(xsum - (RW+1)'(HOUT - 1)) : xsum[RW-1:0];
  assign yr_next = ywrap ? RW'(ysum - (RW+1)'(HOUT - 1)) : ysum[RW-1:0];

  assign x_hi = (xr == '0) ? xi : xi + 1'b1;
  assign y_hi = (yr == '0) ? yi : yi + 1'b1;
  assign wx   = wt[xr];
  assign wy   = wt[yr];
  assign p00  = mem[pix_addr(yi, xi)];
  assign p01  = mem[pix_addr(yi, x_hi)];
  assign p10  = mem[pix_addr(y_hi, xi)];
  assign p11  = mem[pix_addr(y_hi, x_hi)];

  assign adv         = !out_valid || out_ready;
  assign issue_valid = (state == RUN);
  assign row_end     = (ox == RW'(HOUT - 1));
  assign frame_end   = row_end && (oy == RW'(HOUT - 1));

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem[lcnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      lcnt     <= '0;
      ox       <= '0;
      oy       <= '0;
      xi       <= '0;
      xr       <= '0;
      yi       <= '0;
      yr       <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            lcnt <= lcnt + 1'b1;
            if (lcnt == AW'(NPIX - 1)) begin
              lcnt     <= '0;
              state    <= RUN;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              ox       <= '0;
              oy       <= '0;
              xi       <= '0;
              xr       <= '0;
              yi       <= '0;
              yr       <= '0;
            end
          end
        end
        RUN: begin
          if (adv) begin
            if (row_end) begin
              ox <= '0;
              xi <= '0;
              xr <= '0;
              if (frame_end) begin
                state <= DRAIN;
                oy    <= '0;
                yi    <= '0;
                yr    <= '0;
              end else begin
                oy <= oy + 1'b1;
                yi <= ywrap ? yi + 1'b1 : yi;
                yr <= yr_next;
              end
            end else begin
              ox <= ox + 1'b1;
              xi <= xwrap ? xi + 1'b1 : xi;
              xr <= xr_next;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  bilinear_interp_pipe #(
    .FRAC_W(FRAC_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .adv        (adv),
    .issue_valid(issue_valid),
    .issue_last (frame_end),
    .p00        (p00),
    .p01        (p01),
    .p10        (p10),
    .p11        (p11),
    .wx         (wx),
    .wy         (wy),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_bilinear_upsample_stream.sv
// Randomized scoreboard bench for bilinear_upsample_stream against a direct-formula model.
module tb_bilinear_upsample_stream;

  localparam int HIN  = 19;
  localparam int HOUT = 27;
  localparam int F    = 8;
  localparam int NPIX = HIN * HIN;
  localparam int NOUT = HOUT * HOUT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  bilinear_upsample_stream #(.HIN(HIN), .HOUT(HOUT), .FRAC_W(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  int   total = 0;
  int   bad = 0;
  int   exp_q[$];
  int   fr[NPIX];
  int   obs[NOUT];
  int   obs3[NOUT];
  int   out_cnt = 0;
  bit   rnd_ready = 1'b0;
  bit   held_vld = 1'b0;
  int   held_dat = 0;
  int   held_last = 0;
  bit   last_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic abort_run(input string name);
    total++;
    bad++;
    $display("FAIL %s bound expired t=%0t", name, $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "run aborted");
  endtask

  // Source position of output k is k*(HIN-1)/(HOUT-1), computed directly by division.
  function automatic int ref_pix(input int i, input int j);
    int sy, sx, y0, y1, x0, x1, ry, rx, wy, wx, ht, hb, v;
    sy = i * (HIN - 1);
    sx = j * (HIN - 1);
    y0 = sy / (HOUT - 1);
    ry = sy % (HOUT - 1);
    x0 = sx / (HOUT - 1);
    rx = sx % (HOUT - 1);
    y1 = (ry != 0) ? y0 + 1 : y0;
    x1 = (rx != 0) ? x0 + 1 : x0;
    wy = (ry * (1 << F) + (HOUT - 1) / 2) / (HOUT - 1);
    wx = (rx * (1 << F) + (HOUT - 1) / 2) / (HOUT - 1);
    ht = fr[y0 * HIN + x0] * ((1 << F) - wx) + fr[y0 * HIN + x1] * wx;
    hb = fr[y1 * HIN + x0] * ((1 << F) - wx) + fr[y1 * HIN + x1] * wx;
    v  = (ht * ((1 << F) - wy) + hb * wy + (1 << (2 * F - 1))) >> (2 * F);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < HOUT; i++)
      for (int j = 0; j < HOUT; j++)
        exp_q.push_back(ref_pix(i, j) | (((i == HOUT - 1) && (j == HOUT - 1)) ? 256 : 0));
  endtask

  task automatic load_frame(input int gap_pct);
    bit ok;
    for (int i = 0; i < NPIX; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = 8'(fr[i]);
      ok = 1'b0;
      for (int n = 0; n < 5000; n++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) abort_run("load_handshake");
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) abort_run("drain");
    @(posedge clk);
    #1;
  endtask

  // Called right after the final input handshake edge: RUN has just been entered.
  task automatic check_first_valid();
    int first = -1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_valid && first < 0) first = t;
    end
    chk("first_valid_latency", first, 2);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    int e;
    if (rst) begin
      held_vld  = 1'b0;
      out_cnt   = 0;
      last_seen = 1'b0;
    end else begin
      if (last_seen) begin
        chk("in_ready_after_last", int'(in_ready), 1);
        chk("busy_after_last", int'(busy), 0);
        last_seen = 1'b0;
      end
      if (held_vld) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), held_dat);
        chk("stall_last", int'(out_last), held_last);
      end
      held_vld  = out_valid && !out_ready;
      held_dat  = int'(out_data);
      held_last = int'(out_last);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), e & 255);
          chk("out_last", int'(out_last), e >> 8);
        end
        if (out_cnt < NOUT) obs[out_cnt] = int'(out_data);
        out_cnt++;
        if (out_last) begin
          out_cnt   = 0;
          last_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    int mism;
    bit ok;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_last", int'(out_last), 0);
    @(posedge clk);
    #1;

    // Constant map
    for (int i = 0; i < NPIX; i++) fr[i] = 100;
    push_frame();
    load_frame(0);
    check_first_valid();
    wait_drain();
    chk("const_mid", obs[364], 100);

    // Horizontal ramp
    for (int r = 0; r < HIN; r++)
      for (int c = 0; c < HIN; c++) fr[r * HIN + c] = 10 * c;
    push_frame();
    load_frame(0);
    wait_drain();
    chk("ramp_0_0", obs[0], 0);
    chk("ramp_0_1", obs[1], 7);
    chk("ramp_0_13", obs[13], 90);
    chk("ramp_0_26", obs[26], 180);

    // Random map, free-flowing output
    for (int i = 0; i < NPIX; i++) fr[i] = int'($urandom_range(255));
    push_frame();
    load_frame(0);
    wait_drain();
    chk("corner_tl", obs[0], fr[0]);
    chk("corner_tr", obs[HOUT - 1], fr[HIN - 1]);
    chk("corner_bl", obs[(HOUT - 1) * HOUT], fr[(HIN - 1) * HIN]);
    chk("corner_br", obs[NOUT - 1], fr[NPIX - 1]);
    for (int i = 0; i < NOUT; i++) obs3[i] = obs[i];

    // Same map with input gaps and random backpressure
    rnd_ready = 1'b1;
    push_frame();
    load_frame(30);
    check_first_valid();
    wait_drain();
    mism = 0;
    for (int i = 0; i < NOUT; i++) if (obs[i] != obs3[i]) mism++;
    chk("stalled_seq_vs_free", mism, 0);

    // Reset on the 100th output handshake, then a fresh constant frame
    for (int i = 0; i < NPIX; i++) fr[i] = int'($urandom_range(255));
    push_frame();
    load_frame(0);
    ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      if (out_cnt >= 100) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) abort_run("reach_100th_output");
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    chk("midreset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NPIX; i++) fr[i] = 55;
    push_frame();
    load_frame(0);
    wait_drain();
    chk("const55_mid", obs[400], 55);

    // in_valid held with junk through RUN/DRAIN, then a back-to-back frame
    for (int i = 0; i < NPIX; i++) fr[i] = int'($urandom_range(255));
    push_frame();
    load_frame(0);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      chk("in_ready_while_busy", int'(in_ready), 0);
      in_data = 8'($urandom);
    end
    in_valid = 1'b0;
    if (!ok) abort_run("junk_phase");
    @(posedge clk);
    #1;
    for (int i = 0; i < NPIX; i++) fr[i] = int'($urandom_range(255));
    push_frame();
    load_frame(0);
    wait_drain();
    chk("b2b_corner_br", obs[NOUT - 1], fr[NPIX - 1]);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
